// File: rtl/a_if_capture_fifo_if.sv
// ---------------------------------------------------------------------------
// a_if_capture_fifo_if
// Groups the capture FIFO's sample input and valid/ready output handshake.
//   in_en      sample strobe from the interface counter stage
//   in_data    8-bit value seen on the interface bus (a.w)
//   out_valid  head entry available
//   out_ready  consumer accepts the head entry
//   out_data   head entry value
//   out_wrap   head entry wrap tag
// The master modport is the surrounding environment (producer + consumer);
// the slave modport is the FIFO itself.
// ---------------------------------------------------------------------------
interface a_if_capture_fifo_if;
    logic       in_en;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_wrap;

    modport master (
        output in_en,
        output in_data,
        output out_ready,
        input  out_valid,
        input  out_data,
        input  out_wrap
    );

    modport slave (
        input  in_en,
        input  in_data,
        input  out_ready,
        output out_valid,
        output out_data,
        output out_wrap
    );
endinterface

// File: rtl/a_if_capture_fifo.sv
// ---------------------------------------------------------------------------
// a_if_capture_fifo
// Samples the 8-bit interface bus value on in_en and buffers it in a small
// first-word-fall-through FIFO. Each entry carries a wrap tag that marks an
// 8-bit roll-over relative to the previous sample (e.g. 255 -> 0). Samples
// arriving while the FIFO is full (and not being popped) are dropped and set a
// sticky overflow flag; accepted wrap-tagged entries are counted, saturating.
// Ports:
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   bus       slave side of a_if_capture_fifo_if (sample in, valid/ready out)
//   clr_ovf   synchronous clear of the overflow flag
//   level     number of stored entries
//   overflow  sticky: a sample was dropped while full
//   wrap_cnt  accepted wrap-tagged entries, saturating at all-ones
// ---------------------------------------------------------------------------
module a_if_capture_fifo #(
    parameter int DEPTH  = 4,
    parameter int WCNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    a_if_capture_fifo_if.slave     bus,
    input  logic                   clr_ovf,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow,
    output logic [WCNT_W-1:0]      wrap_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

    logic [7:0]    mem_data [DEPTH];
    logic          mem_wrap [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] rd_ptr_nxt;
    logic [LW-1:0] level_nxt;
    logic          pop;
    logic          push;
    logic          drop;
    logic          wrap;
    logic          prev_vld;
    logic [7:0]    prev_data;
    logic [7:0]    head_data;
    logic          head_wrap;
    logic [7:0]    head_data_nxt;
    logic          head_wrap_nxt;

    assign bus.out_valid = (level != '0);
    assign bus.out_data  = head_data;
    assign bus.out_wrap  = head_wrap;

    // Handshake decode and next-state computation. A full FIFO still accepts
    // a sample when the head is being popped in the same cycle. The head
    // register is reloaded from whichever entry will be at the read pointer
    // after this edge; when that slot is the one being written right now
    // (FIFO empty, or emptying while pushing) the incoming sample is taken
    // directly, giving a registered output one cycle after the push. When
    // the FIFO goes empty the head register keeps its last value.
    always_comb begin
        pop        = bus.out_valid & bus.out_ready;
        push       = bus.in_en & ((level < FULL_LEVEL) | pop);
        drop       = bus.in_en & ~push;
        wrap       = prev_vld & (bus.in_data < prev_data);
        rd_ptr_nxt = pop ? rd_ptr + AW'(1) : rd_ptr;

        level_nxt = level;
        if (push && !pop) begin
            level_nxt = level + LW'(1);
        end else if (pop && !push) begin
            level_nxt = level - LW'(1);
        end

        head_data_nxt = head_data;
        head_wrap_nxt = head_wrap;
        if (level_nxt != '0) begin
            if (push && (rd_ptr_nxt == wr_ptr)) begin
                head_data_nxt = bus.in_data;
                head_wrap_nxt = wrap;
            end else begin
                head_data_nxt = mem_data[rd_ptr_nxt];
                head_wrap_nxt = mem_wrap[rd_ptr_nxt];
            end
        end
    end

    // Entry storage, written at the write pointer on every accepted sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_data[i] <= '0;
                mem_wrap[i] <= 1'b0;
            end
        end else if (push) begin
            mem_data[wr_ptr] <= bus.in_data;
            mem_wrap[wr_ptr] <= wrap;
        end
    end

    // Pointers, fill level and the registered head entry. Pointers are
    // exactly AW bits wide so they wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            head_data <= '0;
            head_wrap <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            rd_ptr    <= rd_ptr_nxt;
            level     <= level_nxt;
            head_data <= head_data_nxt;
            head_wrap <= head_wrap_nxt;
        end
    end

    // Previous-sample tracking for the wrap tag. It follows every sampled
    // value, including dropped ones, so the tag always compares against the
    // value that was actually on the bus last time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_vld  <= 1'b0;
            prev_data <= '0;
        end else if (bus.in_en) begin
            prev_vld  <= 1'b1;
            prev_data <= bus.in_data;
        end
    end

    // Status: overflow is sticky and a drop in the same cycle as a clear
    // leaves it set. wrap_cnt only counts entries that were stored and
    // stops at all-ones instead of rolling over.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
            wrap_cnt <= '0;
        end else begin
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
            if (push && wrap && (wrap_cnt != '1)) begin
                wrap_cnt <= wrap_cnt + WCNT_W'(1);
            end
        end
    end

endmodule
